// File: rtl/ahb_latency_ram_pkg.sv
// ahb_latency_ram_pkg: AHB transfer encodings and RAM responder states shared with the bus manager.
package ahb_latency_ram_pkg;
    localparam logic [1:0] AHB_IDLE   = 2'b00;
    localparam logic [1:0] AHB_BUSY   = 2'b01;
    localparam logic [1:0] AHB_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_SEQ    = 2'b11;
    localparam logic [2:0] AHB_SINGLE = 3'b000;
    typedef enum logic {RAM_READY, RAM_WAIT} ramstate_t;
endpackage

// File: rtl/ahb_latency_ram_wait_counter.sv
// ram_wait_counter: loadable down-counter that times the wait states of one data phase.
module ram_wait_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic          zero
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;

    assign zero = (cnt == '0);
endmodule

// File: rtl/ahb_latency_ram.sv
// ahb_latency_ram: AHB-Lite RAM subordinate with programmable wait states and optional zero-wait SEQ beats.
module ahb_latency_ram
    import ahb_latency_ram_pkg::*;
#(
    parameter int          PA_BITS  = 32,
    parameter int          AHBW     = 32,
    parameter logic [63:0] RANGE    = 64'h0FFF,
    parameter int          LATENCY  = 2,
    parameter int          BURST_EN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                HSELRam,
    input  logic [PA_BITS-1:0]  HADDR,
    input  logic                HWRITE,
    input  logic [1:0]          HTRANS,
    input  logic [2:0]          HBURST,
    input  logic                HREADY,
    input  logic [AHBW-1:0]     HWDATA,
    input  logic [AHBW/8-1:0]   HWSTRB,
    output logic                HREADYRam,
    output logic                HRESPRam,
    output logic [AHBW-1:0]     HRDATARam
);
    localparam int NB = AHBW / 8;
    localparam int BW = $clog2(NB);
    localparam int AW = $clog2(RANGE + 1) - BW;
    localparam int CW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'(LATENCY > 0 ? LATENCY - 1 : 0);

    ramstate_t       state;
    logic [AHBW-1:0] mem [2**AW];
    logic [AHBW-1:0] rd_word;
    logic [AW-1:0]   addr_q, rd_addr;
    logic            wr_q, active, accept, seq, need_wait, load, commit, fetch, cnt_zero;
    logic            unused_addr;

    assign accept    = HSELRam & HREADY & HTRANS[1] & (state == RAM_READY);
    assign seq       = (HTRANS == AHB_SEQ) && (HBURST != AHB_SINGLE);
    assign need_wait = (LATENCY != 0) && (!seq || BURST_EN == 0);
    assign load      = accept & need_wait;
    assign commit    = (state == RAM_READY) & active & wr_q;
    assign fetch     = (accept & ~need_wait & ~HWRITE) | ((state == RAM_WAIT) & cnt_zero & ~wr_q);
    assign rd_addr   = accept ? HADDR[AW+BW-1:BW] : addr_q;
    assign HREADYRam = (state == RAM_READY);
    assign HRESPRam  = 1'b0;
    assign unused_addr = ^{HADDR[PA_BITS-1:AW+BW], HADDR[BW-1:0]};

    ram_wait_counter #(.CW(CW)) u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .dec      (state == RAM_WAIT),
        .load_val (LOAD),
        .zero     (cnt_zero)
    );

    // A write committing on the same edge a read is fetched must be visible to that read.
    always_comb begin
        rd_word = mem[rd_addr];
        for (int b = 0; b < NB; b++)
            if (commit && HWSTRB[b] && addr_q == rd_addr) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
    end

    always_ff @(posedge clk)
        if (commit)
            for (int b = 0; b < NB; b++)
                if (HWSTRB[b]) mem[addr_q][8*b +: 8] <= HWDATA[8*b +: 8];

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= RAM_READY;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            active    <= 1'b0;
            HRDATARam <= '0;
        end else begin
            if (accept) begin
                addr_q <= HADDR[AW+BW-1:BW];
                wr_q   <= HWRITE;
            end
            if (state == RAM_READY) begin
                active <= accept;
                state  <= load ? RAM_WAIT : RAM_READY;
            end else if (cnt_zero) state <= RAM_READY;
            if (fetch) HRDATARam <= rd_word;
        end
endmodule
